// File: rtl/regex_cpu_mem_arbiter_if.sv
// Bus bundle between the regex_cpu cores / instruction memory and the shared-memory arbiter.
// The slave modport is the arbiter's view; the master modport is the cores-plus-memory side.
interface regex_cpu_mem_arbiter_if #(
   parameter int N_CPU             = 4,
   parameter int MEMORY_WIDTH      = 20,
   parameter int MEMORY_ADDR_WIDTH = 11,
   parameter int CNT_WIDTH         = 16
);
   logic [N_CPU-1:0]                   cpu_mem_valid;
   logic [N_CPU*MEMORY_ADDR_WIDTH-1:0] cpu_mem_addr;
   logic [N_CPU-1:0]                   cpu_mem_ready;
   logic [MEMORY_WIDTH-1:0]            cpu_mem_data;
   logic [N_CPU-1:0]                   cpu_rsp_valid;
   logic                               mem_valid;
   logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr;
   logic                               mem_ready;
   logic [MEMORY_WIDTH-1:0]            mem_data;
   logic [CNT_WIDTH-1:0]               contention_cnt;

   modport slave (
      input  cpu_mem_valid, cpu_mem_addr, mem_ready, mem_data,
      output cpu_mem_ready, cpu_mem_data, cpu_rsp_valid, mem_valid, mem_addr, contention_cnt
   );

   modport master (
      output cpu_mem_valid, cpu_mem_addr, mem_ready, mem_data,
      input  cpu_mem_ready, cpu_mem_data, cpu_rsp_valid, mem_valid, mem_addr, contention_cnt
   );
endinterface

// File: rtl/regex_cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported instruction memory between N_CPU regex_cpu cores.
// Grant and address are combinational; the response owner is registered one cycle behind the grant.
module regex_cpu_mem_arbiter #(
   parameter int N_CPU             = 4,
   parameter int MEMORY_WIDTH      = 20,
   parameter int MEMORY_ADDR_WIDTH = 11,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   regex_cpu_mem_arbiter_if.slave bus
);
   localparam int               PTR_W    = (N_CPU > 1) ? $clog2(N_CPU) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CPU - 1);

   logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
   logic [N_CPU-1:0]             rsp_q, rsp_d;
   logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

   logic [PTR_W-1:0]             scan_idx_s;
   logic [PTR_W-1:0]             win_s;
   logic                         win_found_s;
   logic [N_CPU-1:0]             win_onehot_s;
   logic [MEMORY_ADDR_WIDTH-1:0] win_addr_s;
   logic                         mem_valid_s;
   logic                         accept_s;
   logic                         contended_s;

   // Scan requesters starting at rr_ptr and wrapping modulo N_CPU; first hit wins.
   always_comb begin
      scan_idx_s  = '0;
      win_s       = '0;
      win_found_s = 1'b0;
      for (int k = 0; k < N_CPU; k++) begin
         scan_idx_s = PTR_W'((int'(rr_ptr_q) + k) % N_CPU);
         if (!win_found_s && bus.cpu_mem_valid[scan_idx_s]) begin
            win_found_s = 1'b1;
            win_s       = scan_idx_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Decode the winner into a one-hot vector and pick its address slice.
   always_comb begin
      win_onehot_s = '0;
      win_addr_s   = '0;
      for (int i = 0; i < N_CPU; i++) begin
         if (win_found_s && (win_s == PTR_W'(i))) begin
            win_onehot_s[i] = 1'b1;
            win_addr_s      = bus.cpu_mem_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
         end else begin
            win_onehot_s[i] = 1'b0;
         end
      end
   end

   // Handshake detection and next-state for pointer, response owner and contention counter.
   always_comb begin
      mem_valid_s = (|bus.cpu_mem_valid) && !rst;
      accept_s    = mem_valid_s && bus.mem_ready;
      contended_s = ($countones(bus.cpu_mem_valid) >= 32'd2);
      rr_ptr_d    = rr_ptr_q;
      rsp_d       = '0;
      cnt_d       = cnt_q;
      if (accept_s) begin
         rsp_d = win_onehot_s;
         if (win_s == LAST_IDX) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = win_s + PTR_W'(1);
         end
      end else begin
         rsp_d = '0;
      end
      if (contended_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Drive the bus; data is broadcast unregistered since cores sample it one cycle after accept.
   always_comb begin
      bus.mem_valid      = mem_valid_s;
      bus.mem_addr       = win_addr_s;
      bus.cpu_mem_ready  = accept_s ? win_onehot_s : {N_CPU{1'b0}};
      bus.cpu_mem_data   = bus.mem_data;
      bus.cpu_rsp_valid  = rsp_q;
      bus.contention_cnt = cnt_q;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= '0;
         rsp_q    <= '0;
         cnt_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rsp_q    <= rsp_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_regex_cpu_mem_arbiter.sv
// Self-checking bench: a 4-core/16-bit-counter arbiter and a 3-core/4-bit-counter arbiter,
// each compared every cycle against a round-robin reference model, plus directed scenarios.
module tb_regex_cpu_mem_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regex_cpu_mem_arbiter_if #(.N_CPU(4), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .CNT_WIDTH(16)) bus4 ();
   regex_cpu_mem_arbiter_if #(.N_CPU(3), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .CNT_WIDTH(4))  bus3 ();

   regex_cpu_mem_arbiter #(.N_CPU(4), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .CNT_WIDTH(16)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave));
   regex_cpu_mem_arbiter #(.N_CPU(3), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11), .CNT_WIDTH(4))  u_dut3 (
      .clk(clk), .rst(rst), .bus(bus3.slave));

   logic [3:0]  v4;
   logic [43:0] a4;
   logic        mr4;
   logic [19:0] md4;
   logic [2:0]  v3;
   logic [32:0] a3;
   logic        mr3;
   logic [19:0] md3;

   assign bus4.cpu_mem_valid = v4;
   assign bus4.cpu_mem_addr  = a4;
   assign bus4.mem_ready     = mr4;
   assign bus4.mem_data      = md4;
   assign bus3.cpu_mem_valid = v3;
   assign bus3.cpu_mem_addr  = a3;
   assign bus3.mem_ready     = mr3;
   assign bus3.mem_data      = md3;

   // Reference model state: priority pointer, pending response owner, contention count.
   int         p4, c4, p3, c3;
   logic [3:0] r4;
   logic [2:0] r3;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // First requester in rotated order ptr, ptr+1, ... mod n; -1 when nobody requests.
   function automatic int winner(input int n, input int ptr, input logic [7:0] v);
      for (int k = 0; k < n; k++) begin
         if (((v >> ((ptr + k) % n)) & 8'd1) != 8'd0) return (ptr + k) % n;
      end
      return -1;
   endfunction

   task automatic step();
      int         w4, w3;
      logic [3:0] er4;
      logic [2:0] er3;
      @(negedge clk);
      w4  = winner(4, p4, 8'(v4));
      w3  = winner(3, p3, 8'(v3));
      er4 = (!rst && w4 >= 0 && mr4) ? (4'b0001 << w4) : 4'b0000;
      er3 = (!rst && w3 >= 0 && mr3) ? (3'b001 << w3) : 3'b000;

      check_val("n4_ready",     32'(bus4.cpu_mem_ready),  32'(er4));
      check_val("n4_mem_valid", 32'(bus4.mem_valid),      32'(!rst && v4 != 4'd0));
      check_val("n4_mem_addr",  32'(bus4.mem_addr),       (w4 >= 0) ? 32'(11'(a4 >> (w4 * 11))) : 32'd0);
      check_val("n4_data",      32'(bus4.cpu_mem_data),   32'(md4));
      check_val("n4_rsp",       32'(bus4.cpu_rsp_valid),  32'(r4));
      check_val("n4_cnt",       32'(bus4.contention_cnt), 32'(c4));
      check_val("n3_ready",     32'(bus3.cpu_mem_ready),  32'(er3));
      check_val("n3_mem_valid", 32'(bus3.mem_valid),      32'(!rst && v3 != 3'd0));
      check_val("n3_mem_addr",  32'(bus3.mem_addr),       (w3 >= 0) ? 32'(11'(a3 >> (w3 * 11))) : 32'd0);
      check_val("n3_data",      32'(bus3.cpu_mem_data),   32'(md3));
      check_val("n3_rsp",       32'(bus3.cpu_rsp_valid),  32'(r3));
      check_val("n3_cnt",       32'(bus3.contention_cnt), 32'(c3));

      if (rst) begin
         p4 = 0; r4 = 4'd0; c4 = 0;
         p3 = 0; r3 = 3'd0; c3 = 0;
      end else begin
         r4 = er4;
         if (er4 != 4'd0) p4 = (w4 + 1) % 4;
         if ($countones(v4) >= 2 && c4 < 65535) c4++;
         r3 = er3;
         if (er3 != 3'd0) p3 = (w3 + 1) % 3;
         if ($countones(v3) >= 2 && c3 < 15) c3++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      p4 = 0; c4 = 0; r4 = 4'd0;
      p3 = 0; c3 = 0; r3 = 3'd0;
      rst = 1'b1;
      v4 = 4'd0; a4 = 44'd0; mr4 = 1'b1; md4 = 20'd0;
      v3 = 3'd0; a3 = 33'd0; mr3 = 1'b1; md3 = 20'd0;
      step();
      step();
      check_val("reset_rsp", 32'(bus4.cpu_rsp_valid), 32'd0);
      check_val("reset_cnt", 32'(bus4.contention_cnt), 32'd0);
      rst = 1'b0;

      // All four cores request with memory always ready; core 0 and core 2 of the 3-core unit contend.
      v4 = 4'b1111;
      v3 = 3'b101;
      for (int i = 0; i < 8; i++) begin
         a4  = 44'({$urandom(), $urandom()});
         a3  = 33'({$urandom(), $urandom()});
         md4 = 20'($urandom());
         #1;
         check_val("rr_cycle", 32'(bus4.cpu_mem_ready), 32'(4'b0001 << (i % 4)));
         step();
      end
      check_val("cnt_after_8", 32'(bus4.contention_cnt), 32'd8);

      // Single requester: core 2 fetching 0x05A.
      v4 = 4'b0100;
      a4 = 44'({$urandom(), $urandom()});
      a4[22 +: 11] = 11'h05A;
      #1;
      check_val("c2_ready", 32'(bus4.cpu_mem_ready), 32'h4);
      check_val("c2_addr",  32'(bus4.mem_addr),      32'h05A);
      step();
      v4  = 4'b0000;
      md4 = 20'h3ABCD;
      #1;
      check_val("c2_rsp",  32'(bus4.cpu_rsp_valid), 32'h4);
      check_val("c2_data", 32'(bus4.cpu_mem_data),  32'h3ABCD);
      step();

      // Grant to core 1, then reset the following cycle: the response is dropped.
      v4 = 4'b0010;
      step();
      v4  = 4'b0000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check_val("rst_rsp_drop", 32'(bus4.cpu_rsp_valid), 32'd0);
      check_val("rst_cnt",      32'(bus4.contention_cnt), 32'd0);

      // Cores 1 and 3 stalled by memory for 3 cycles, then released.
      v4  = 4'b1010;
      mr4 = 1'b0;
      a4  = 44'({$urandom(), $urandom()});
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("stall_ready", 32'(bus4.cpu_mem_ready), 32'd0);
         check_val("stall_addr",  32'(bus4.mem_addr),      32'(a4[11 +: 11]));
         step();
      end
      mr4 = 1'b1;
      #1;
      check_val("release_c1", 32'(bus4.cpu_mem_ready), 32'h2);
      step();
      check_val("release_c3", 32'(bus4.cpu_mem_ready), 32'h8);
      step();
      v4 = 4'b0001;
      #1;
      check_val("ptr_wrapped", 32'(bus4.cpu_mem_ready), 32'h1);
      step();

      // Let the 4-bit counter run well past its ceiling.
      v3 = 3'b101;
      for (int i = 0; i < 20; i++) step();
      check_val("n3_cnt_sat", 32'(bus3.contention_cnt), 32'd15);

      // Randomized traffic with occasional stalls and resets.
      for (int i = 0; i < 400; i++) begin
         v4  = 4'($urandom_range(0, 15));
         a4  = 44'({$urandom(), $urandom()});
         mr4 = ($urandom_range(0, 3) != 0);
         md4 = 20'($urandom());
         v3  = 3'($urandom_range(0, 7));
         a3  = 33'({$urandom(), $urandom()});
         mr3 = ($urandom_range(0, 3) != 0);
         md3 = 20'($urandom());
         rst = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
